// File: rtl/servant_spi_ram_ctrl.sv
// SPI mode-0 slave that turns READ (0x03) / WRITE (0x02) commands into accesses on the
// servant byte-wide RAM port. Define SPI_RAM_CTRL_RDSR_EN to answer RDSR (0x05) with 8'h40.
module servant_spi_ram_ctrl #(
  parameter int aw = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_sclk,
  input  logic          i_cs_n,
  input  logic          i_mosi,
  output logic          o_miso,
  output logic [aw-1:0] o_addr,
  output logic [7:0]    o_wdata,
  output logic          o_we_n,
  output logic          o_re,
  input  logic [7:0]    i_rdata
);

  localparam int SW = (aw > 8) ? aw : 8;
  localparam logic [aw-1:0] ADDR_ONE = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RD_SHIFT,
    S_WR_SHIFT,
    S_WR_COMMIT,
    S_IGNORE,
    S_STATUS
  } state_t;

  state_t        r_state;
  logic [1:0]    r_sclk_s;
  logic [1:0]    r_cs_s;
  logic [1:0]    r_mosi_s;
  logic          r_sclk_d;
  logic          r_cs_d;
  logic [4:0]    r_bit_cnt;
  logic [SW-2:0] r_sh;
  logic          r_is_write;
  logic [7:0]    r_tx;
  logic [7:0]    r_hold;
  logic [2:0]    r_tx_cnt;
  logic [1:0]    r_fetch;
  logic [1:0]    r_commit_cnt;

  logic          w_sclk_rise;
  logic          w_sclk_fall;
  logic          w_cs_fall;
  logic          w_cs_high;
  logic          w_mosi;
  logic [SW-1:0] w_sh_next;

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_d;
  assign w_cs_fall   = ~r_cs_s[1] & r_cs_d;
  assign w_cs_high   = r_cs_s[1];
  assign w_mosi      = r_mosi_s[1];
  assign w_sh_next   = {r_sh, w_mosi};

  // Synchronizers reset to the bus-idle levels so leaving reset never fakes a CS fall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclk_s <= 2'b00;
      r_cs_s   <= 2'b11;
      r_mosi_s <= 2'b00;
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_sclk_s <= {r_sclk_s[0], i_sclk};
      r_cs_s   <= {r_cs_s[0], i_cs_n};
      r_mosi_s <= {r_mosi_s[0], i_mosi};
      r_sclk_d <= r_sclk_s[1];
      r_cs_d   <= r_cs_s[1];
    end
  end

  // RAM port protocol: o_addr settles one cycle before o_re or o_we_n, each strobe lasts
  // exactly two cycles, read data is taken in the second o_re cycle, and the two strobes
  // are never active together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 5'd0;
      r_sh         <= '0;
      r_is_write   <= 1'b0;
      r_tx         <= 8'h00;
      r_hold       <= 8'h00;
      r_tx_cnt     <= 3'd0;
      r_fetch      <= 2'd0;
      r_commit_cnt <= 2'd0;
      o_miso       <= 1'b0;
      o_addr       <= '0;
      o_wdata      <= 8'h00;
      o_we_n       <= 1'b1;
      o_re         <= 1'b0;
    end else begin
      case (r_fetch)
        2'd1: begin
          o_re    <= 1'b1;
          r_fetch <= 2'd2;
        end
        2'd2: r_fetch <= 2'd3;
        2'd3: begin
          o_re    <= 1'b0;
          r_fetch <= 2'd0;
          o_addr  <= o_addr + ADDR_ONE;
          if (r_state == S_DUMMY) r_tx <= i_rdata;
          else r_hold <= i_rdata;
        end
        default: ;
      endcase

      if (w_cs_high && r_state != S_IDLE && r_state != S_WR_COMMIT) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 5'd0;
        o_miso    <= 1'b0;
        o_re      <= 1'b0;
        r_fetch   <= 2'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            o_miso <= 1'b0;
            if (w_cs_fall) begin
              r_state   <= S_CMD;
              r_bit_cnt <= 5'd0;
            end
          end

          S_CMD: begin
            if (w_sclk_rise) begin
              r_sh <= w_sh_next[SW-2:0];
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= 5'd0;
                case (w_sh_next[7:0])
                  8'h03: begin
                    r_is_write <= 1'b0;
                    r_state    <= S_ADDR;
                  end
                  8'h02: begin
                    r_is_write <= 1'b1;
                    r_state    <= S_ADDR;
                  end
`ifdef SPI_RAM_CTRL_RDSR_EN
                  8'h05: begin
                    r_tx     <= 8'h40;
                    r_tx_cnt <= 3'd0;
                    r_state  <= S_STATUS;
                  end
`endif
                  default: r_state <= S_IGNORE;
                endcase
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end

          S_ADDR: begin
            if (w_sclk_rise) begin
              r_sh <= w_sh_next[SW-2:0];
              if (r_bit_cnt == 5'd23) begin
                r_bit_cnt <= 5'd0;
                o_addr    <= w_sh_next[aw-1:0];
                if (r_is_write) begin
                  r_state <= S_WR_SHIFT;
                end else begin
                  r_state <= S_DUMMY;
                  r_fetch <= 2'd1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end

          S_DUMMY: begin
            if (w_sclk_rise) begin
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= 5'd0;
                r_tx_cnt  <= 3'd0;
                r_state   <= S_RD_SHIFT;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end

          // The first fall of each byte launches the next prefetch; the hold register is
          // swapped in on the fall that puts out bit 0, so the next fall starts a new byte.
          S_RD_SHIFT: begin
            if (w_sclk_fall) begin
              o_miso   <= r_tx[3'd7 - r_tx_cnt];
              r_tx_cnt <= r_tx_cnt + 3'd1;
              if (r_tx_cnt == 3'd0) r_fetch <= 2'd1;
              if (r_tx_cnt == 3'd7) r_tx <= r_hold;
            end
          end

          S_WR_SHIFT: begin
            if (w_sclk_rise) begin
              r_sh <= w_sh_next[SW-2:0];
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt    <= 5'd0;
                o_wdata      <= w_sh_next[7:0];
                r_commit_cnt <= 2'd0;
                r_state      <= S_WR_COMMIT;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end

          S_WR_COMMIT: begin
            case (r_commit_cnt)
              2'd0: begin
                o_we_n       <= 1'b0;
                r_commit_cnt <= 2'd1;
              end
              2'd1: r_commit_cnt <= 2'd2;
              default: begin
                o_we_n       <= 1'b1;
                r_commit_cnt <= 2'd0;
                o_addr       <= o_addr + ADDR_ONE;
                r_state      <= w_cs_high ? S_IDLE : S_WR_SHIFT;
              end
            endcase
          end

          S_IGNORE: o_miso <= 1'b0;

`ifdef SPI_RAM_CTRL_RDSR_EN
          S_STATUS: begin
            if (w_sclk_fall) begin
              o_miso   <= r_tx[3'd7 - r_tx_cnt];
              r_tx_cnt <= r_tx_cnt + 3'd1;
            end
          end
`endif

          default: begin
            r_state <= S_IDLE;
            o_miso  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
